// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the i_cache / d_cache memory port arbiter.
//   owner_t          : which master owns a granted / outstanding request
//   SIZE_BYTE/HALF/WORD : sram-like transfer size encodings
//   other_owner()    : the owner that is not the one given
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// ----------------------------------------------------------------------------
// arb_owner_fifo
// Synchronous FIFO of owner_t recording who issued each accepted request.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue the head (ignored when empty)
//   head       : owner at the head of the queue
//   full/empty : status flags
// Parameter DEPTH: number of entries (power of 2, >= 1).
// ----------------------------------------------------------------------------
module arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  owner_t din,
    output owner_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    owner_t        slots [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Explicit wrap keeps the pointers correct even when DEPTH is 1.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        else                     return p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one sram-like memory port between the i_cache (inst_*) and the
// d_cache (data_*) masters. Address phases are arbitrated combinationally,
// the owner of every accepted request is queued, and in-order responses are
// steered back to that owner with zero added latency.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   inst_* / data_* (in)          : req, wr, size, addr, wdata from each master
//   inst_* / data_* (out)         : rdata (broadcast), addr_ok, data_ok
//   mem_* (out)                   : req, wr, size, addr, wdata to the bridge
//   mem_rdata/addr_ok/data_ok (in): responses from the bridge
//   proto_err                     : sticky, data_ok seen with nothing outstanding
// Configuration macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests
// alternate between masters; otherwise data always wins over inst.
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic        proto_err
);

    owner_t grant;
    owner_t lock_owner;
    owner_t head;
    logic   lock;
    logic   grant_valid;
    logic   grant_req;
    logic   full;
    logic   empty;
    logic   handshake;
    logic   pop;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_grant;
`endif

    // A stalled address phase keeps its owner until the bridge accepts it,
    // so the address seen by the bridge never changes mid-handshake.
    always_comb begin
        grant = OWNER_INST;
        if (lock) begin
            grant = lock_owner;
`ifdef ARB_ROUND_ROBIN_EN
        end else if (data_req && inst_req) begin
            grant = other_owner(last_grant);
`endif
        end else if (data_req) begin
            grant = OWNER_DATA;
        end else begin
            grant = OWNER_INST;
        end
    end

    assign grant_valid = lock | data_req | inst_req;
    assign grant_req   = (grant == OWNER_DATA) ? data_req : inst_req;
    assign mem_req     = grant_req & ~full;
    assign handshake   = mem_req & mem_addr_ok;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (grant_valid) begin
            if (grant == OWNER_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign inst_addr_ok = handshake & (grant == OWNER_INST);
    assign data_addr_ok = handshake & (grant == OWNER_DATA);

    // Responses arrive in issue order, so the FIFO head names their owner.
    assign pop          = mem_data_ok & ~empty;
    assign inst_data_ok = pop & (head == OWNER_INST);
    assign data_data_ok = pop & (head == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (handshake),
        .pop   (pop),
        .din   (grant),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Lock is released by the bridge's address acceptance, even if the
    // locked master has (illegally) withdrawn its request meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock       <= 1'b0;
            lock_owner <= OWNER_INST;
            proto_err  <= 1'b0;
        end else begin
            if (mem_req && !mem_addr_ok) begin
                lock       <= 1'b1;
                lock_owner <= grant;
            end else if (mem_addr_ok) begin
                lock <= 1'b0;
            end
            if (mem_data_ok && empty) proto_err <= 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            last_grant <= OWNER_INST;
        else if (handshake) last_grant <= grant;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (MAX_OUTSTANDING = 2). Inputs change
// 1 ns after the rising edge; outputs are compared 1 ns later.
// Honours ARB_ROUND_ROBIN_EN for the simultaneous-request expectations.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic        proto_err;

    int vectors;
    int miscompares;
    logic exp_second_inst;

    mem_port_arbiter #(
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h, want %08h", tag, got, want);
        end
    endtask

    // Drives one cycle of stimulus; data writes use byte size, data wdata = ~addr.
    task automatic apply_stimulus(input logic i_req, input logic [31:0] i_addr,
                                  input logic d_req, input logic d_wr, input logic [31:0] d_addr,
                                  input logic a_ok, input logic d_ok, input logic [31:0] rdata);
        inst_req    = i_req;
        inst_wr     = 1'b0;
        inst_size   = i_req ? SIZE_WORD : SIZE_BYTE;
        inst_addr   = i_req ? i_addr : 32'h0;
        inst_wdata  = 32'h0;
        data_req    = d_req;
        data_wr     = d_req & d_wr;
        data_size   = (d_req && !d_wr) ? SIZE_WORD : SIZE_BYTE;
        data_addr   = d_req ? d_addr : 32'h0;
        data_wdata  = d_req ? ~d_addr : 32'h0;
        mem_addr_ok = a_ok;
        mem_data_ok = d_ok;
        mem_rdata   = rdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_second_inst = 1'b1;
`else
        exp_second_inst = 1'b0;
`endif
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_mem_req",   32'(mem_req), 0);
        check_output("rst_mem_addr",  mem_addr, 0);
        check_output("rst_proto_err", 32'(proto_err), 0);
        check_output("rst_i_aok",     32'(inst_addr_ok), 0);
        check_output("rst_d_dok",     32'(data_data_ok), 0);
        rst = 1'b0;
        tick();

        // Single data read, response three cycles after acceptance.
        apply_stimulus(0, 0, 1, 0, 32'h8000_0010, 1, 0, 0);
        check_output("t1_mem_req",  32'(mem_req), 1);
        check_output("t1_mem_addr", mem_addr, 32'h8000_0010);
        check_output("t1_mem_size", 32'(mem_size), 32'(SIZE_WORD));
        check_output("t1_d_aok",    32'(data_addr_ok), 1);
        check_output("t1_i_aok",    32'(inst_addr_ok), 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check_output("t1_d_dok",  32'(data_data_ok), 1);
        check_output("t1_rdata",  data_rdata, 32'hDEAD_BEEF);
        check_output("t1_i_dok",  32'(inst_data_ok), 0);
        tick();

        // Simultaneous requests from a freshly reset arbiter.
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        apply_stimulus(1, 32'h0000_1000, 1, 0, 32'h8000_0020, 1, 0, 0);
        check_output("t2_first_d_aok", 32'(data_addr_ok), 1);
        check_output("t2_first_i_aok", 32'(inst_addr_ok), 0);
        check_output("t2_first_addr",  mem_addr, 32'h8000_0020);
        tick();
        apply_stimulus(1, 32'h0000_1000, 1, 0, 32'h8000_0030, 1, 0, 0);
        check_output("t2_second_i_aok", 32'(inst_addr_ok), 32'(exp_second_inst));
        check_output("t2_second_d_aok", 32'(data_addr_ok), 32'(!exp_second_inst));
        check_output("t2_second_addr",  mem_addr, exp_second_inst ? 32'h0000_1000 : 32'h8000_0030);
        tick();
        apply_stimulus(1, 32'h0000_1000, 1, 0, 32'h8000_0030, 1, 0, 0);
        check_output("t2_full_mem_req", 32'(mem_req), 0);
        check_output("t2_full_i_aok",   32'(inst_addr_ok), 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
        check_output("t2_pop1_d_dok", 32'(data_data_ok), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
        check_output("t2_pop2_i_dok", 32'(inst_data_ok), 32'(exp_second_inst));
        check_output("t2_pop2_d_dok", 32'(data_data_ok), 32'(!exp_second_inst));
        tick();

        // Stalled inst request keeps the port even when data_req arrives.
        apply_stimulus(1, 32'h0000_2000, 0, 0, 0, 0, 0, 0);
        check_output("lk_mem_req", 32'(mem_req), 1);
        check_output("lk_i_aok",   32'(inst_addr_ok), 0);
        tick();
        apply_stimulus(1, 32'h0000_2000, 1, 0, 32'h8000_0040, 0, 0, 0);
        check_output("lk_addr",  mem_addr, 32'h0000_2000);
        check_output("lk_d_aok", 32'(data_addr_ok), 0);
        tick();
        apply_stimulus(1, 32'h0000_2000, 1, 0, 32'h8000_0040, 1, 0, 0);
        check_output("lk_rel_i_aok", 32'(inst_addr_ok), 1);
        check_output("lk_rel_d_aok", 32'(data_addr_ok), 0);
        tick();
        apply_stimulus(0, 0, 1, 0, 32'h8000_0040, 1, 0, 0);
        check_output("lk_next_d_aok", 32'(data_addr_ok), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h3333_3333);
        check_output("lk_pop1_i_dok", 32'(inst_data_ok), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h4444_4444);
        check_output("lk_pop2_d_dok", 32'(data_data_ok), 1);
        tick();

        // Data write stalled for four cycles while inst_req rises.
        apply_stimulus(0, 0, 1, 1, 32'h8000_0050, 0, 0, 0);
        check_output("t3_mem_req",   32'(mem_req), 1);
        check_output("t3_mem_wr",    32'(mem_wr), 1);
        check_output("t3_mem_wdata", mem_wdata, 32'h7FFF_FFAF);
        check_output("t3_d_aok",     32'(data_addr_ok), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 32'h0000_3000, 1, 1, 32'h8000_0050, 0, 0, 0);
            check_output("t3_hold_addr",  mem_addr, 32'h8000_0050);
            check_output("t3_hold_i_aok", 32'(inst_addr_ok), 0);
            tick();
        end
        apply_stimulus(1, 32'h0000_3000, 1, 1, 32'h8000_0050, 1, 0, 0);
        check_output("t3_d_aok_hs", 32'(data_addr_ok), 1);
        tick();
        apply_stimulus(1, 32'h0000_3000, 0, 0, 0, 1, 0, 0);
        check_output("t3_i_aok",   32'(inst_addr_ok), 1);
        check_output("t3_i_addr",  mem_addr, 32'h0000_3000);
        check_output("t3_i_wr",    32'(mem_wr), 0);
        tick();

        // Two outstanding: third request is held off until a pop.
        apply_stimulus(1, 32'h0000_4000, 0, 0, 0, 1, 0, 0);
        check_output("t4_full_req",   32'(mem_req), 0);
        check_output("t4_full_i_aok", 32'(inst_addr_ok), 0);
        tick();
        apply_stimulus(1, 32'h0000_4000, 0, 0, 0, 1, 1, 32'h5555_5555);
        check_output("t4_pop_d_dok",   32'(data_data_ok), 1);
        check_output("t4_pop_i_dok",   32'(inst_data_ok), 0);
        check_output("t4_pop_mem_req", 32'(mem_req), 0);
        tick();
        apply_stimulus(1, 32'h0000_4000, 0, 0, 0, 1, 0, 0);
        check_output("t4_after_req",   32'(mem_req), 1);
        check_output("t4_after_i_aok", 32'(inst_addr_ok), 1);
        tick();

        // Responses steered with pushes and pops in the same cycle.
        apply_stimulus(0, 0, 1, 0, 32'h8000_0070, 1, 1, 32'h6666_6666);
        check_output("t5_pop_i_dok", 32'(inst_data_ok), 1);
        check_output("t5_mem_req",   32'(mem_req), 0);
        tick();
        apply_stimulus(0, 0, 1, 0, 32'h8000_0070, 1, 1, 32'h7777_7777);
        check_output("t5_pp1_i_dok", 32'(inst_data_ok), 1);
        check_output("t5_pp1_d_aok", 32'(data_addr_ok), 1);
        tick();
        apply_stimulus(1, 32'h0000_5000, 0, 0, 0, 1, 1, 32'h8888_8888);
        check_output("t5_pp2_d_dok", 32'(data_data_ok), 1);
        check_output("t5_pp2_i_dok", 32'(inst_data_ok), 0);
        check_output("t5_pp2_i_aok", 32'(inst_addr_ok), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h9999_9999);
        check_output("t5_last_i_dok", 32'(inst_data_ok), 1);
        check_output("t5_rdata",      inst_rdata, 32'h9999_9999);
        tick();

        // Spurious response, sticky error, and mid-transaction reset.
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'hAAAA_AAAA);
        check_output("t6_i_dok",       32'(inst_data_ok), 0);
        check_output("t6_d_dok",       32'(data_data_ok), 0);
        check_output("t6_perr_before", 32'(proto_err), 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t6_perr", 32'(proto_err), 1);
        tick();
        tick();
        check_output("t6_perr_held", 32'(proto_err), 1);
        apply_stimulus(0, 0, 1, 0, 32'h8000_0090, 1, 0, 0);
        check_output("t6_d_aok", 32'(data_addr_ok), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_output("t6_rst_perr", 32'(proto_err), 0);
        tick();
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'hBBBB_BBBB);
        check_output("t6_after_rst_d_dok", 32'(data_data_ok), 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t6_perr_again", 32'(proto_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_output("idle_mem_req",   32'(mem_req), 0);
        check_output("idle_mem_addr",  mem_addr, 0);
        check_output("idle_mem_wdata", mem_wdata, 0);
        check_output("idle_proto_err", 32'(proto_err), 0);
        check_output("idle_i_dok",     32'(inst_data_ok), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
